// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Multi-cycle adder/subtractor. A WIDTH-bit operand pair is summed STEP bits
// per clock through a STEP-bit ripple chain of full-adder cells. A registered
// carry links one step to the next, so wide words use a small datapath.
// Subtraction is a + ~b + ~cin. Operands and mode are captured with start, so
// the inputs may change while an operation is running.
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   STEP   bits per cycle (must divide WIDTH); latency N = WIDTH/STEP cycles
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   operation request, sampled only while busy = 0
//   sub     in   0 = add, 1 = subtract (captured with start)
//   a, b    in   operands (captured with start)
//   cin     in   carry-in (add) / borrow-in (sub) (captured with start)
//   busy    out  operation in progress
//   done    out  one-cycle pulse: sum/cout/ovf were just updated
//   sum     out  result, held until the next completion
//   cout    out  raw carry out of the MSB (sub: 1 = no borrow)
//   ovf     out  two's-complement overflow of the completed operation
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic             carry_q;
  logic [WIDTH-1:0] acc_q;     // result shift register, filled from the MSB side
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  // ---------------------------------------------------------------------------
  // STEP-bit ripple chain. chain_c[i] is the carry into cell i; chain_c[0] is
  // the registered carry from the previous step.
  // ---------------------------------------------------------------------------
  logic [STEP:0]    chain_c;
  logic [STEP-1:0]  chain_s;
  logic [WIDTH-1:0] chain_s_ext;
  logic [WIDTH-1:0] acc_d;
  logic             ovf_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    chain_c    = '0;
    chain_s    = '0;
    chain_c[0] = carry_q;
    for (int i = 0; i < STEP; i++) begin
      chain_s[i]     = opa_q[i] ^ opb_q[i] ^ chain_c[i];
      chain_c[i+1]   = (opa_q[i] & opb_q[i]) | (chain_c[i] & (opa_q[i] ^ opb_q[i]));
    end
  end

  // New bits enter at the top; after N steps bit 0 of the word sits at acc[0].
  assign chain_s_ext = WIDTH'(chain_s);
  assign acc_d       = (acc_q >> STEP) | (chain_s_ext << (WIDTH - STEP));

  // On the final step the top cell of the chain is bit WIDTH-1 of the word, so
  // the carries into and out of that cell give the signed overflow.
  assign ovf_d = chain_c[STEP] ^ chain_c[STEP-1];

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge value of the others, independent of statement order.
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            opa_q   <= a;
            opb_q   <= sub ? ~b : b;
            carry_q <= sub ^ cin;          // sub ? ~cin : cin
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          opa_q   <= opa_q >> STEP;
          opb_q   <= opb_q >> STEP;
          carry_q <= chain_c[STEP];
          acc_q   <= acc_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) begin
            sum_q   <= acc_d;
            cout_q  <= chain_c[STEP];
            ovf_q   <= ovf_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
